// File: rtl/poly_search_engine.sv
// Parallel LFSR polynomial search: finds which candidate polynomial carries data0
// to data1 in a step count consistent with the timestamp delta.
module poly_search_lane #(
    parameter int POLY_W = 17
) (
    input  logic              clk_72MHz,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [POLY_W-1:0] seed,
    input  logic [POLY_W-1:0] poly,
    input  logic [POLY_W-1:0] target,
    output logic              match
);
    logic [POLY_W-1:0] val;

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n)    val <= '0;
        else if (load) val <= seed;
        else if (step) val <= val[0] ? ((val >> 1) ^ poly) : (val >> 1);
    end

    assign match = (val == target);
endmodule

module poly_search_engine #(
    parameter int NUM_POLY = 4,
    parameter int POLY_W   = 17,
    parameter int TS_W     = 24,
    parameter int TS_SHIFT = 4,
    parameter int ITER_TOL = 2,
    parameter int MAX_ITER = 4095,
    localparam int ITER_W  = $clog2(MAX_ITER + ITER_TOL + 2),
    localparam int PIDX_W  = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1
) (
    input  logic                       clk_72MHz,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NUM_POLY*POLY_W-1:0] poly_table,
    input  logic [POLY_W-1:0]          data0,
    input  logic [POLY_W-1:0]          data1,
    input  logic [TS_W-1:0]            ts0,
    input  logic [TS_W-1:0]            ts1,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic                       err,
    output logic [PIDX_W-1:0]          poly_index,
    output logic [POLY_W-1:0]          polynomial,
    output logic [ITER_W-1:0]          iteration
);
    typedef enum logic [1:0] {IDLE, ESTIMATE, RUN, DONE} state_t;

    localparam logic [TS_W-1:0]   MAX_EST = TS_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] TOL     = ITER_W'(ITER_TOL);

    state_t state, state_nxt;
    logic [NUM_POLY-1:0][POLY_W-1:0] tbl_q;
    logic [POLY_W-1:0] d0_q, d1_q;
    logic [TS_W-1:0]   t0_q, t1_q, delta, est;
    logic [ITER_W-1:0] est_i, cnt, win_lo, win_hi;
    logic [NUM_POLY-1:0] match;
    logic              est_bad, in_win, hit, lane_load, lane_step;
    logic [PIDX_W-1:0] hit_idx;
    logic [POLY_W-1:0] hit_poly;

    // Modular subtraction absorbs timestamp wrap-around.
    assign delta   = t1_q - t0_q;
    assign est     = delta >> TS_SHIFT;
    assign est_i   = ITER_W'(est);
    assign est_bad = (delta == '0) || (d0_q == d1_q) || (est > MAX_EST);
    assign in_win  = (cnt >= win_lo) && (cnt <= win_hi);
    assign done    = (state == DONE);

    for (genvar g = 0; g < NUM_POLY; g++) begin : g_lane
        poly_search_lane #(.POLY_W(POLY_W)) u_lane (
            .clk_72MHz (clk_72MHz),
            .rst_n     (rst_n),
            .load      (lane_load),
            .step      (lane_step),
            .seed      (d0_q),
            .poly      (tbl_q[g]),
            .target    (d1_q),
            .match     (match[g])
        );
    end

    // Scan high to low so the lowest matching lane wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_poly = '0;
        for (int i = NUM_POLY - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_idx  = PIDX_W'(i);
                hit_poly = tbl_q[i];
            end
        end
    end

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lane_load = 1'b0;
        lane_step = 1'b0;
        case (state)
            IDLE:     if (start && !abort) state_nxt = ESTIMATE;
            ESTIMATE: begin
                if (abort)        state_nxt = IDLE;
                else if (est_bad) state_nxt = DONE;
                else begin
                    lane_load = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort)                state_nxt = IDLE;
                else if (in_win && hit)   state_nxt = DONE;
                else if (cnt > win_hi)    state_nxt = DONE;
                else                      lane_step = 1'b1;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_72MHz or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0; found <= 1'b0; err <= 1'b0;
            poly_index <= '0; polynomial <= '0; iteration <= '0;
            tbl_q <= '0; d0_q <= '0; d1_q <= '0; t0_q <= '0; t1_q <= '0;
            cnt <= '0; win_lo <= '0; win_hi <= '0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    tbl_q <= poly_table;
                    d0_q  <= data0; d1_q <= data1;
                    t0_q  <= ts0;   t1_q <= ts1;
                    busy  <= 1'b1;
                    found <= 1'b0; err <= 1'b0;
                    poly_index <= '0; polynomial <= '0; iteration <= '0;
                end
                ESTIMATE, RUN: begin
                    if (abort) begin
                        busy <= 1'b0; found <= 1'b0; err <= 1'b0;
                        poly_index <= '0; polynomial <= '0; iteration <= '0;
                    end else if (state == ESTIMATE) begin
                        if (est_bad) begin
                            err   <= 1'b1;
                            found <= 1'b0;
                        end else begin
                            cnt    <= '0;
                            win_lo <= (est_i >= TOL) ? est_i - TOL : '0;
                            win_hi <= est_i + TOL;
                        end
                    end else if (in_win && hit) begin
                        found      <= 1'b1;
                        poly_index <= hit_idx;
                        polynomial <= hit_poly;
                        iteration  <= cnt;
                    end else if (cnt <= win_hi) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_poly_search_engine.sv
// Randomized bench for poly_search_engine against a direct model of the search rules.
module tb_poly_search_engine;
    localparam int NP = 4, PW = 17, TW = 24, IW = 13;

    logic              clk_72MHz = 1'b0;
    logic              rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [NP*PW-1:0]  poly_table = '0;
    logic [PW-1:0]     data0 = '0, data1 = '0;
    logic [TW-1:0]     ts0 = '0, ts1 = '0;
    logic              busy, done, found, err;
    logic [1:0]        poly_index;
    logic [PW-1:0]     polynomial;
    logic [IW-1:0]     iteration;

    int checks = 0, failures = 0;

    poly_search_engine dut (
        .clk_72MHz(clk_72MHz), .rst_n(rst_n), .start(start), .abort(abort),
        .poly_table(poly_table), .data0(data0), .data1(data1), .ts0(ts0), .ts1(ts1),
        .busy(busy), .done(done), .found(found), .err(err),
        .poly_index(poly_index), .polynomial(polynomial), .iteration(iteration)
    );

    always #5 clk_72MHz = ~clk_72MHz;

    typedef struct {
        bit           err;
        bit           found;
        int           idx;
        logic [PW-1:0] poly;
        int           iter;
        int           lat;
    } res_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] v, input logic [PW-1:0] p);
        return v[0] ? ((v >> 1) ^ p) : (v >> 1);
    endfunction

    // Walk every candidate forward from data0, accepting the first step count inside the window.
    function automatic res_t model(input logic [NP*PW-1:0] t, input logic [PW-1:0] d0,
                                   input logic [PW-1:0] d1, input logic [TW-1:0] a,
                                   input logic [TW-1:0] b);
        res_t r;
        logic [TW-1:0] delta;
        logic [PW-1:0] v [NP];
        int est, lo, hi;
        r = '{default: 0};
        delta = b - a;
        est = int'(delta >> 4);
        if (delta == 0 || d0 == d1 || est > 4095) begin
            r.err = 1; r.lat = 2;
            return r;
        end
        lo = (est > 2) ? est - 2 : 0;
        hi = est + 2;
        for (int i = 0; i < NP; i++) v[i] = d0;
        for (int k = 0; k <= hi; k++) begin
            if (k >= lo)
                for (int i = 0; i < NP; i++)
                    if (v[i] == d1) begin
                        r.found = 1; r.idx = i; r.poly = t[i*PW +: PW];
                        r.iter = k; r.lat = k + 3;
                        return r;
                    end
            for (int i = 0; i < NP; i++) v[i] = lfsr_step(v[i], t[i*PW +: PW]);
        end
        r.lat = hi + 4;
        return r;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NP; i++) poly_table[i*PW +: PW] = PW'($urandom());
        data0 = PW'($urandom()); data1 = PW'($urandom());
        ts0 = TW'($urandom()); ts1 = TW'($urandom());
    endtask

    task automatic run(input string nm, input logic [NP*PW-1:0] t, input logic [PW-1:0] d0,
                       input logic [PW-1:0] d1, input logic [TW-1:0] a, input logic [TW-1:0] b,
                       input bit poke);
        res_t e;
        int n;
        e = model(t, d0, d1, a, b);
        @(negedge clk_72MHz);
        poly_table = t; data0 = d0; data1 = d1; ts0 = a; ts1 = b; start = 1'b1;
        @(negedge clk_72MHz);
        start = 1'b0;
        scramble();
        n = 1;
        check({nm, " busy"}, busy, 1);
        while (n < 5000) begin
            if (done) break;
            start = (poke && n == 2);
            @(negedge clk_72MHz);
            start = 1'b0;
            n++;
        end
        check({nm, " latency"}, n, e.lat);
        check({nm, " found"}, found, e.found);
        check({nm, " err"}, err, e.err);
        check({nm, " index"}, poly_index, e.idx);
        check({nm, " poly"}, polynomial, e.poly);
        check({nm, " iter"}, iteration, e.iter);
        @(negedge clk_72MHz);
        check({nm, " done_pulse"}, {busy, done}, 2'b00);
        check({nm, " held"}, {found, err, polynomial}, {e.found, e.err, e.poly});
    endtask

    logic [NP*PW-1:0] t23, t25, tr;
    logic [PW-1:0]    pr [NP];
    logic [PW-1:0]    d0r, d1r;
    logic [TW-1:0]    a;
    int               k, est, c, mode;
    bit               saw_done;

    initial begin
        t23 = {17'h17E04, 17'h1D258, 17'h17E04, 17'h1D258};
        t25 = {17'h1D258, 17'h17E04, 17'h1D258, 17'h17E04};
        #1;
        check("reset outputs", {busy, done, found, err, poly_index, polynomial, iteration}, '0);
        @(negedge clk_72MHz);
        rst_n = 1'b1;

        run("basic", t23, 17'h00002, 17'h17E04, 24'h000100, 24'h000120, 0);
        check("basic const", {found, poly_index, polynomial, iteration}, {1'b1, 2'd1, 17'h17E04, 13'd2});
        run("wrap", t23, 17'h00002, 17'h17E04, 24'hFFFFF0, 24'h000010, 1);
        check("wrap const", {found, poly_index, iteration}, {1'b1, 2'd1, 13'd2});
        run("prio", t25, 17'h00002, 17'h17E04, 24'h000100, 24'h000120, 0);
        check("prio const", {found, poly_index, polynomial}, {1'b1, 2'd0, 17'h17E04});
        run("nomatch", t23, 17'h00002, 17'h12345, 24'h000100, 24'h000120, 0);
        check("nomatch const", {found, err, iteration}, {1'b0, 1'b0, 13'd0});
        run("zero_delta", t23, 17'h00002, 17'h17E04, 24'h000100, 24'h000100, 0);
        check("zero_delta const", {found, err}, 2'b01);
        run("same_data", t23, 17'h00002, 17'h00002, 24'h000100, 24'h000120, 0);
        run("est_over", t23, 17'h00002, 17'h17E04, 24'h000100, 24'h010100, 0);
        run("est_max", t23, 17'h00003, 17'h12345, 24'h000000, 24'h00FFF0, 0);

        // Abort lands on the cycle the match would be taken.
        @(negedge clk_72MHz);
        poly_table = t23; data0 = 17'h00002; data1 = 17'h17E04; ts0 = 24'h100; ts1 = 24'h120;
        start = 1'b1;
        @(negedge clk_72MHz); start = 1'b0;
        repeat (3) @(negedge clk_72MHz);
        abort = 1'b1;
        @(negedge clk_72MHz); abort = 1'b0;
        check("abort clear", {busy, done, found, err, poly_index, polynomial, iteration}, '0);
        saw_done = 0;
        repeat (8) begin @(negedge clk_72MHz); saw_done |= done; end
        check("abort no_done", saw_done, 0);

        // Start with abort in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk_72MHz); start = 1'b0; abort = 1'b0;
        check("start_abort idle", busy, 0);
        saw_done = 0;
        repeat (6) begin @(negedge clk_72MHz); saw_done |= done; end
        check("start_abort no_done", saw_done, 0);

        // Reset clears a held result asynchronously, then discards a running search.
        run("pre_reset", t25, 17'h00002, 17'h17E04, 24'h000100, 24'h000120, 0);
        #2 rst_n = 1'b0;
        #1 check("reset held", {found, poly_index, polynomial, iteration}, '0);
        @(negedge clk_72MHz); rst_n = 1'b1;
        poly_table = t23; data0 = 17'h00002; data1 = 17'h17E04; ts0 = 24'h100; ts1 = 24'h120;
        start = 1'b1;
        @(negedge clk_72MHz); start = 1'b0;
        repeat (2) @(negedge clk_72MHz);
        check("midrun busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check("midrun reset", {busy, done, found, err, poly_index, polynomial, iteration}, '0);
        @(negedge clk_72MHz); rst_n = 1'b1;
        saw_done = 0;
        repeat (8) begin @(negedge clk_72MHz); saw_done |= done; end
        check("midrun no_done", saw_done, 0);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NP; i++) pr[i] = PW'($urandom());
            if ($urandom_range(0, 3) == 0) pr[2] = pr[1];
            for (int i = 0; i < NP; i++) tr[i*PW +: PW] = pr[i];
            d0r = PW'($urandom());
            if (d0r == '0) d0r = 1;
            c = $urandom_range(0, NP - 1);
            k = $urandom_range(1, 24);
            d1r = d0r;
            for (int s = 0; s < k; s++) d1r = lfsr_step(d1r, pr[c]);
            mode = $urandom_range(0, 5);
            if (mode == 0) d1r = PW'($urandom());
            est = k + $urandom_range(0, 4) - 2;
            if (mode == 1) est = k + 3 + $urandom_range(0, 5);
            if (est < 0) est = 0;
            a = TW'($urandom());
            run($sformatf("rand%0d", it), tr, d0r, d1r, a, a + TW'(est * 16 + $urandom_range(0, 15)),
                bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/poly_search_engine.md
POLY_SEARCH_ENGINE -- requirements
Module: poly_search_engine

Interface
REQ-001 SHALL have parameter NUM_POLY, default 4: number of candidate polynomials searched in parallel (1..8).
REQ-002 SHALL have parameter POLY_W, default 17: LFSR and polynomial width.
REQ-003 SHALL have parameter TS_W, default 24: timestamp width.
REQ-004 SHALL have parameter TS_SHIFT, default 4: right shift converting timestamp delta to the iteration estimate.
REQ-005 SHALL have parameter ITER_TOL, default 2: +/- iteration tolerance window.
REQ-006 SHALL have parameter MAX_ITER, default 4095: largest accepted estimate; ITER_W = clog2(MAX_ITER+ITER_TOL+2).
REQ-007 SHALL have ports (name  direction  width  meaning), clock and reset first:
- clk_72MHz  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  cancel search
- poly_table  in  NUM_POLY*POLY_W  candidates, entry i at bits [i*POLY_W +: POLY_W]
- data0, data1  in  POLY_W each  first/second decoded LFSR words
- ts0, ts1  in  TS_W each  timestamps of data0/data1
- busy  out  1  search in progress
- done  out  1  one-cycle result strobe
- found  out  1  match found (valid with done, held)
- err  out  1  input rejected (valid with done, held)
- poly_index  out  clog2(NUM_POLY) (min 1)  matching entry
- polynomial  out  POLY_W  matching polynomial
- iteration  out  ITER_W  step count from data0 to data1

Function
REQ-008 SHALL implement states IDLE, ESTIMATE, RUN, DONE.
REQ-009 IDLE: start=1 -> capture data0, data1, ts0, ts1, poly_table into internal registers; busy<=1; go ESTIMATE. Inputs may change afterwards without effect.
REQ-010 ESTIMATE (1 cycle): delta = (ts1 - ts0) mod 2^TS_W (wrap-around handled by modular subtraction); est = delta >> TS_SHIFT.
REQ-011 ESTIMATE: if delta==0, data0==data1, or est>MAX_ITER -> err<=1, found<=0, go DONE; else load every channel LFSR with data0, iteration counter <=0, win_lo = max(est-ITER_TOL,0) (saturating), win_hi = est+ITER_TOL, go RUN.
REQ-012 LFSR step, per channel i: if value[0]==1 then value <= (value>>1) ^ poly_i else value <= value>>1.
REQ-013 RUN, each cycle: evaluate registered values at current counter; if win_lo <= counter <= win_hi and any value_i == data1 -> record lowest matching i, its polynomial, counter; found<=1; go DONE; else step all LFSRs and increment counter.
REQ-014 RUN: counter > win_hi with no match -> found<=0, err<=0, go DONE; worst-case RUN length win_hi+2 cycles.
REQ-015 Simultaneous matches on several channels SHALL resolve to the lowest index.
REQ-016 DONE (1 cycle): done=1, busy<=0, go IDLE; found, err, poly_index, polynomial, iteration held until next start.
REQ-017 New start in IDLE clears found, err, poly_index, polynomial, iteration to 0 in the same edge as capture.
REQ-018 abort=1 in ESTIMATE or RUN -> IDLE next edge, busy<=0, no done pulse, result outputs cleared to 0; abort has priority over match.
REQ-019 start while busy SHALL be ignored; start and abort together in IDLE -> abort wins, remain IDLE.
REQ-020 Latency: match at iteration k -> done asserted k+3 cycles after the start cycle.

Reset
REQ-021 rst_n low SHALL asynchronously force state IDLE, busy=0, done=0, found=0, err=0, poly_index=0, polynomial=0, iteration=0, all LFSRs and counter 0.
REQ-022 Release of rst_n SHALL be effective on the next clk_72MHz edge; reset mid-search discards the search without done.

Verification
REQ-023 poly_table={0x1D258,0x17E04,0x1D258,0x17E04}, data0=0x00002, data1=0x17E04, ts0=0x000100, ts1=0x000120, start -> est=2, done 5 cycles after start, found=1, poly_index=1, polynomial=0x17E04, iteration=2.
REQ-024 Same as REQ-023 with ts0=0xFFFFF0, ts1=0x000010 -> identical result (wrap-around).
REQ-025 poly_table={0x17E04,0x1D258,0x17E04,0x1D258}, REQ-023 data -> poly_index=0 (lowest-index priority).
REQ-026 data1=0x12345, REQ-023 timestamps -> done with found=0, err=0, iteration=0; ts1=ts0 -> done after ESTIMATE with err=1.
REQ-027 abort pulsed 2 cycles into RUN -> busy low next edge, no done, outputs 0; rst_n pulsed mid-RUN -> all outputs 0 immediately.
